ramread_trace: RTL and testbench

- Read-side counterpart of the ADC capture writer.
- Owns a two-bank sample RAM: 2 x 160 bytes, with a registered 1-cycle read.
- Reads the bank not being written, scans it against VGA pixel counters, and outputs a 1-bit trace pixel for the 640x480 display.
- Swaps banks only at frame start, so the display never tears, and throttles the writer through its enable.

---
 rtl/ramread_trace.sv | 167 ++++++++++++++++
 tb/tb_ramread_trace.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ramread_trace.sv
// ramread_trace: read side of the two-bank capture RAM. Scans the display
// bank against the VGA pixel counters and emits a 1-bit trace pixel with
// 2 cycles of latency. Banks swap only at frame start; the writer is
// throttled through fill_enable.
// Optional feature: define TRACE_FILL_EN to draw vertical segments joining
// adjacent samples instead of isolated dots.
module ramread_trace #(
    parameter int SAMPLES    = 160,
    parameter int X_SHIFT    = 2,
    parameter int TRACE_BASE = 367
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fill_done,
    input  logic       frame_start,
    input  logic       freeze,
    input  logic [9:0] CounterX,
    input  logic [9:0] CounterY,
    input  logic       inDisplayArea,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       buf_sel,
    output logic       fill_enable,
    output logic       trace_valid,
    output logic       trace_pixel
);

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] SHOW    = 2'd2;

    localparam logic [9:0] BASE     = 10'(TRACE_BASE);
    localparam logic [9:0] LAST_COL = 10'(SAMPLES - 1);

    logic [1:0] state;
    logic [9:0] col;
    logic [9:0] row_cur;
    logic       pixel_hit;

    // Stage-1 companions of the RAM read
    logic [9:0] d_y;
    logic       d_de;
    logic       d_valid;

    // Column-to-sample address, clamped to the last sample past the capture
    always_comb begin
        col     = CounterX >> X_SHIFT;
        rd_addr = (col >= 10'(SAMPLES)) ? LAST_COL[7:0] : col[7:0];
    end

    // Bank ownership and writer throttle
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            buf_sel     <= 1'b0;
            fill_enable <= 1'b1;
            trace_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (fill_done && frame_start) begin
                        buf_sel     <= ~buf_sel;
                        trace_valid <= 1'b1;
                        fill_enable <= ~freeze;
                        state       <= SHOW;
                    end else if (fill_done) begin
                        fill_enable <= 1'b0;
                        state       <= PENDING;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        buf_sel     <= ~buf_sel;
                        trace_valid <= 1'b1;
                        fill_enable <= 1'b1;
                        state       <= SHOW;
                    end
                end
                SHOW: begin
                    if (fill_done && !freeze && frame_start) begin
                        buf_sel     <= ~buf_sel;
                        fill_enable <= 1'b1;
                    end else if (fill_done && !freeze) begin
                        fill_enable <= 1'b0;
                        state       <= PENDING;
                    end else begin
                        fill_enable <= ~freeze;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Stage 1: delay the pixel context to line up with the RAM read data
    always_ff @(posedge clk) begin
        if (reset) begin
            d_y     <= '0;
            d_de    <= 1'b0;
            d_valid <= 1'b0;
        end else begin
            d_y     <= CounterY;
            d_de    <= inDisplayArea;
            d_valid <= trace_valid;
        end
    end

    // TRACE_BASE >= 255 keeps this subtraction from wrapping
    always_comb row_cur = BASE - {2'b00, rd_data};

`ifdef TRACE_FILL_EN
    logic [7:0] d_addr;
    logic       d_col0;
    logic [7:0] last_addr;
    logic [7:0] last_sample;
    logic [7:0] prev_sample;
    logic [7:0] prev_eff;
    logic [9:0] row_prev;
    logic [9:0] row_lo;
    logic [9:0] row_hi;

    // Track the sample of the previous column; at column 0 there is no
    // previous column, so the segment collapses onto the current dot.
    always_comb begin
        prev_eff = prev_sample;
        if (d_col0)
            prev_eff = rd_data;
        else if (d_addr != last_addr)
            prev_eff = last_sample;
        row_prev = BASE - {2'b00, prev_eff};
        row_lo   = (row_prev < row_cur) ? row_prev : row_cur;
        row_hi   = (row_prev < row_cur) ? row_cur : row_prev;
        pixel_hit = (d_y >= row_lo) && (d_y <= row_hi);
    end

    // Previous-column sample history, aligned with stage 2
    always_ff @(posedge clk) begin
        if (reset) begin
            d_addr      <= '0;
            d_col0      <= 1'b0;
            last_addr   <= '0;
            last_sample <= '0;
            prev_sample <= '0;
        end else begin
            d_addr      <= rd_addr;
            d_col0      <= (CounterX == '0);
            last_addr   <= d_addr;
            last_sample <= rd_data;
            prev_sample <= prev_eff;
        end
    end
`else
    // Dot trace: lit only on the row that matches the sample
    always_comb pixel_hit = (d_y == row_cur);
`endif

    // Stage 2: registered trace pixel
    always_ff @(posedge clk) begin
        if (reset)
            trace_pixel <= 1'b0;
        else
            trace_pixel <= d_de & d_valid & pixel_hit;
    end

endmodule

// File: tb/tb_ramread_trace.sv
// Directed bench for ramread_trace with a bench-owned two-bank RAM and a
// pixel scoreboard (expected pixel queued at drive time, compared 2 cycles later).
module tb_ramread_trace;

    localparam int SAMPLES = 160;
    localparam int BASE    = 367;

    typedef struct {
        int   x;
        int   y;
        logic v;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset, fill_done, frame_start, freeze, inDisplayArea;
    logic [9:0] CounterX, CounterY;
    logic [7:0] rd_addr, rd_data;
    logic       buf_sel, fill_enable, trace_valid, trace_pixel;

    logic [7:0] mem [0:2*SAMPLES-1];
    pix_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cur_bank = 0;
    bit         cur_valid = 1'b0;

    ramread_trace #(.SAMPLES(SAMPLES), .X_SHIFT(2), .TRACE_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .fill_done(fill_done), .frame_start(frame_start),
        .freeze(freeze), .CounterX(CounterX), .CounterY(CounterY),
        .inDisplayArea(inDisplayArea), .rd_addr(rd_addr), .rd_data(rd_data),
        .buf_sel(buf_sel), .fill_enable(fill_enable), .trace_valid(trace_valid),
        .trace_pixel(trace_pixel)
    );

    always #5 clk = ~clk;

    // Registered 1-cycle RAM read
    always @(posedge clk) rd_data <= mem[(buf_sel ? SAMPLES : 0) + int'(rd_addr)];

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic exp_pix(input int x, input int y, input bit de);
        int a, s, p, rc, rp, lo, hi;
        if (!(de && cur_valid)) return 1'b0;
        a = x >> 2;
        if (a > SAMPLES - 1) a = SAMPLES - 1;
        s  = int'(mem[cur_bank*SAMPLES + a]);
        rc = BASE - s;
`ifdef TRACE_FILL_EN
        p  = (a == 0) ? s : int'(mem[cur_bank*SAMPLES + a - 1]);
        rp = BASE - p;
        lo = (rp < rc) ? rp : rc;
        hi = (rp < rc) ? rc : rp;
        return (y >= lo) && (y <= hi);
`else
        p = s; rp = rc; lo = rc; hi = rc;
        return y == rc;
`endif
    endfunction

    // One pixel clock: drive, queue expectation, advance, compare oldest
    task automatic cyc(input int x, input int y, input bit de, input bit fs = 1'b0, input bit fd = 1'b0);
        pix_t e, o;
        CounterX = 10'(x);
        CounterY = 10'(y);
        inDisplayArea = de;
        frame_start = fs;
        fill_done = fd;
        e.x = x; e.y = y; e.v = exp_pix(x, y, de);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        fill_done = 1'b0;
        if (exp_q.size() >= 2) begin
            o = exp_q.pop_front();
            chk($sformatf("pixel x=%0d y=%0d", o.x, o.y), int'(trace_pixel), int'(o.v));
        end
    endtask

    task automatic scan_row(input int y);
        for (int x = 0; x < 800; x++) cyc(x, y, x < 640);
    endtask

    initial begin
        reset = 1'b1; fill_done = 1'b0; frame_start = 1'b0; freeze = 1'b0;
        CounterX = '0; CounterY = '0; inDisplayArea = 1'b0;
        for (int i = 0; i < SAMPLES; i++) begin
            mem[i] = 8'h00;
            mem[SAMPLES + i] = 8'h40;
        end
        repeat (3) cyc(0, 0, 0);
        reset = 1'b0;
        chk("reset buf_sel", int'(buf_sel), 0);
        chk("reset fill_enable", int'(fill_enable), 1);
        chk("reset trace_valid", int'(trace_valid), 0);
        chk("reset trace_pixel", int'(trace_pixel), 0);
        chk("reset rd_addr", int'(rd_addr), 0);

        // Idle: nothing drawn even where bank 0 data would match
        scan_row(367);
        scan_row(303);
        chk("idle buf_sel", int'(buf_sel), 0);
        chk("idle fill_enable", int'(fill_enable), 1);
        chk("idle trace_valid", int'(trace_valid), 0);

        // fill_done at row 200 then frame_start
        for (int x = 0; x < 50; x++) cyc(x, 200, 1);
        cyc(50, 200, 1, 0, 1);
        chk("pending fill_enable", int'(fill_enable), 0);
        chk("pending buf_sel", int'(buf_sel), 0);
        for (int x = 51; x < 800; x++) cyc(x, 200, x < 640);
        chk("pending hold fill_enable", int'(fill_enable), 0);
        chk("pending trace_valid", int'(trace_valid), 0);
        cyc(0, 0, 1, 1, 0);
        chk("swap buf_sel", int'(buf_sel), 1);
        chk("swap trace_valid", int'(trace_valid), 1);
        chk("swap fill_enable", int'(fill_enable), 1);
        cur_bank = 1; cur_valid = 1'b1;

        // Constant 0x40 bank: only row 303 lit
        scan_row(302);
        scan_row(303);
        scan_row(304);

        // Address clamp
        cyc(635, 0, 0); chk("rd_addr x=635", int'(rd_addr), 158);
        cyc(636, 0, 0); chk("rd_addr x=636", int'(rd_addr), 159);
        cyc(799, 0, 0); chk("rd_addr x=799", int'(rd_addr), 159);
        cyc(17, 0, 0);  chk("rd_addr x=17", int'(rd_addr), 4);

        // Same-cycle fill_done + frame_start in SHOW, bank 0 holds a ramp
        for (int i = 0; i < SAMPLES; i++) mem[i] = 8'(i);
        cyc(0, 0, 0, 1, 1);
        chk("show swap buf_sel", int'(buf_sel), 0);
        chk("show swap fill_enable", int'(fill_enable), 1);
        chk("show swap trace_valid", int'(trace_valid), 1);
        cur_bank = 0;
        cyc(0, 0, 0);
        chk("show swap fill_enable hold", int'(fill_enable), 1);
        scan_row(327);
        scan_row(367);

        // Still in SHOW: lone fill_done goes to PENDING
        cyc(0, 0, 0, 0, 1);
        chk("show->pending fill_enable", int'(fill_enable), 0);
        cyc(0, 0, 0, 1, 0);
        chk("pending->show buf_sel", int'(buf_sel), 1);
        chk("pending->show fill_enable", int'(fill_enable), 1);
        cur_bank = 1;

        // Freeze holds the displayed bank
        freeze = 1'b1;
        cyc(0, 0, 0);
        chk("freeze fill_enable", int'(fill_enable), 0);
        for (int f = 0; f < 3; f++) begin
            cyc(0, 0, 0, 1, f == 1);
            chk($sformatf("freeze buf_sel f%0d", f), int'(buf_sel), 1);
            cyc(5, 0, 0);
        end
        chk("freeze fill_enable held", int'(fill_enable), 0);
        freeze = 1'b0;
        cyc(0, 0, 0);
        chk("unfreeze fill_enable", int'(fill_enable), 1);
        scan_row(303);

        // Reset mid-capture discards the pending fill
        cyc(0, 0, 0, 0, 1);
        chk("pre-reset fill_enable", int'(fill_enable), 0);
        reset = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0;
        cur_bank = 0; cur_valid = 1'b0;
        chk("midreset buf_sel", int'(buf_sel), 0);
        chk("midreset fill_enable", int'(fill_enable), 1);
        chk("midreset trace_valid", int'(trace_valid), 0);
        cyc(0, 0, 0, 1, 0);
        chk("empty frame_start buf_sel", int'(buf_sel), 0);
        chk("empty frame_start trace_valid", int'(trace_valid), 0);

        // EMPTY with fill_done + frame_start together goes straight to SHOW
        cyc(0, 0, 0, 1, 1);
        chk("empty swap buf_sel", int'(buf_sel), 1);
        chk("empty swap trace_valid", int'(trace_valid), 1);
        chk("empty swap fill_enable", int'(fill_enable), 1);
        cur_bank = 1; cur_valid = 1'b1;
        scan_row(303);

`ifdef TRACE_FILL_EN
        mem[SAMPLES + 3] = 8'h10;
        mem[SAMPLES + 4] = 8'h20;
        for (int y = 300; y < 356; y++)
            for (int x = 0; x < 21; x++) cyc(x, y, 1);
`endif

        repeat (3) cyc(0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
